buzzer_scheduler: RTL and testbench

BUZZER_SCHEDULER -- requirements
Module: buzzer_scheduler

---
 rtl/buzzer_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_buzzer_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler
// Arbitrates one physical buzzer between a countdown timer and an alarm.
// The alarm has priority and preempts a ringing timer. The timer resumes
// once the alarm is silenced or snoozed. Each ring stops by itself after
// TIMEOUT_SEC cycles. The alarm can be snoozed up to MAX_SNOOZE times per
// alarm event. One clock cycle is one second.
//
// Ports
//   clk         : 1 Hz system clock, rising edge
//   reset       : synchronous active-high reset
//   timer_req   : timer expiry level; only its rising edge starts a ring
//   alarm_req   : alarm match level; only its rising edge starts a ring
//   stop_btn    : one-cycle pulse, silences the active source / cancels snooze
//   snooze_btn  : one-cycle pulse, snoozes a ringing alarm
//   buzzer      : buzzer drive (steady for timer, 1 s on / 1 s off for alarm)
//   active_src  : 00 none, 01 timer, 10 alarm
//   snoozing    : high while a snooze countdown is running
//   snooze_left : remaining snooze cycles
module buzzer_scheduler #(
  parameter int SNOOZE_SEC  = 300,
  parameter int TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timer_req,
  input  logic       alarm_req,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic       snoozing,
  output logic [8:0] snooze_left
);

  // State codes double as the active_src encoding.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    RING_TIMER = 2'b01,
    RING_ALARM = 2'b10
  } state_e;

  localparam logic [5:0] RING_LAST   = 6'(TIMEOUT_SEC - 1);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic       timer_req_q, alarm_req_q;
  logic       init_q;
  logic       timer_pend_q, timer_pend_d;
  logic       alarm_pend_q, alarm_pend_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic [8:0] snooze_left_q, snooze_left_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic       buzzer_q, buzzer_d;
  logic       snoozing_q;
  logic [1:0] active_src_q;
  logic       timer_rise_s, alarm_rise_s, ring_end_s, ring_stop_s;

  // Next-state computation for pending flags, snooze bookkeeping and ring timing.
  always_comb begin
    // init_q masks the first cycle after reset, so a request level that is
    // still high when reset releases does not look like a fresh edge.
    timer_rise_s  = timer_req & ~timer_req_q & ~init_q;
    alarm_rise_s  = alarm_req & ~alarm_req_q & ~init_q;
    ring_end_s    = (state_q != IDLE) && (ring_cnt_q == RING_LAST);
    ring_stop_s   = 1'b0;
    timer_pend_d  = timer_pend_q | timer_rise_s;
    alarm_pend_d  = alarm_pend_q;
    snooze_left_d = snooze_left_q;
    snooze_cnt_d  = snooze_cnt_q;

    // Snooze countdown. Expiry re-arms the alarm but keeps the snooze count.
    if (snooze_left_q != 9'd0) begin
      snooze_left_d = snooze_left_q - 9'd1;
      if (snooze_left_q == 9'd1) begin
        alarm_pend_d = 1'b1;
      end else begin
        alarm_pend_d = alarm_pend_q;
      end
    end else begin
      snooze_left_d = 9'd0;
    end

    // A fresh alarm starts a new event and discards any running snooze.
    // OR-ing into the flag means a coincident expiry cannot double it.
    if (alarm_rise_s) begin
      alarm_pend_d = 1'b1;
      if (snooze_left_q != 9'd0) begin
        snooze_left_d = 9'd0;
        snooze_cnt_d  = 2'd0;
      end else begin
        snooze_cnt_d  = snooze_cnt_q;
      end
    end else begin
      ring_stop_s = 1'b0;
    end

    // Buttons and the auto-stop act on the source that is ringing now.
    // stop_btn is tested first, so it wins over snooze_btn.
    case (state_q)
      RING_TIMER: begin
        if (stop_btn || ring_end_s) begin
          timer_pend_d = 1'b0;
          ring_stop_s  = 1'b1;
        end else begin
          ring_stop_s  = 1'b0;
        end
      end
      RING_ALARM: begin
        if (stop_btn || ring_end_s || (snooze_btn && (snooze_cnt_q >= SNOOZE_MAX))) begin
          alarm_pend_d = 1'b0;
          snooze_cnt_d = 2'd0;
          ring_stop_s  = 1'b1;
        end else if (snooze_btn) begin
          alarm_pend_d  = 1'b0;
          snooze_left_d = SNOOZE_LOAD;
          snooze_cnt_d  = snooze_cnt_q + 2'd1;
          ring_stop_s   = 1'b1;
        end else begin
          ring_stop_s   = 1'b0;
        end
      end
      IDLE: begin
        if (stop_btn && (snooze_left_q != 9'd0)) begin
          snooze_left_d = 9'd0;
          snooze_cnt_d  = 2'd0;
        end else begin
          ring_stop_s   = 1'b0;
        end
      end
      default: begin
        ring_stop_s = 1'b0;
      end
    endcase

    if (alarm_pend_d) begin
      state_d = RING_ALARM;
    end else if (timer_pend_d) begin
      state_d = RING_TIMER;
    end else begin
      state_d = IDLE;
    end

    // Every ring, including a resumed one, starts counting from zero.
    if ((state_d != state_q) || ring_stop_s) begin
      ring_cnt_d = 6'd0;
    end else if (state_q != IDLE) begin
      ring_cnt_d = ring_cnt_q + 6'd1;
    end else begin
      ring_cnt_d = 6'd0;
    end

    // The alarm pattern starts with an on-second because ring_cnt starts even.
    buzzer_d = (state_d == RING_TIMER) ||
               ((state_d == RING_ALARM) && !ring_cnt_d[0]);
  end

  // State, request history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_req_q   <= 1'b0;
      alarm_req_q   <= 1'b0;
      init_q        <= 1'b1;
      timer_pend_q  <= 1'b0;
      alarm_pend_q  <= 1'b0;
      ring_cnt_q    <= 6'd0;
      snooze_left_q <= 9'd0;
      snooze_cnt_q  <= 2'd0;
      buzzer_q      <= 1'b0;
      snoozing_q    <= 1'b0;
      active_src_q  <= 2'b00;
    end else begin
      state_q       <= state_d;
      timer_req_q   <= timer_req;
      alarm_req_q   <= alarm_req;
      init_q        <= 1'b0;
      timer_pend_q  <= timer_pend_d;
      alarm_pend_q  <= alarm_pend_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_left_q <= snooze_left_d;
      snooze_cnt_q  <= snooze_cnt_d;
      buzzer_q      <= buzzer_d;
      snoozing_q    <= (snooze_left_d != 9'd0);
      active_src_q  <= state_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign active_src  = active_src_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed testbench for buzzer_scheduler (SNOOZE_SEC=5, TIMEOUT_SEC=8, MAX_SNOOZE=2).
module tb_buzzer_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       timer_req = 1'b0;
  logic       alarm_req = 1'b0;
  logic       stop_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       buzzer;
  logic [1:0] active_src;
  logic       snoozing;
  logic [8:0] snooze_left;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_scheduler #(
    .SNOOZE_SEC(5),
    .TIMEOUT_SEC(8),
    .MAX_SNOOZE(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .timer_req  (timer_req),
    .alarm_req  (alarm_req),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .active_src (active_src),
    .snoozing   (snoozing),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are stable 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %0b expected 0", buzzer); end
    n_checks++;
    if (active_src !== 2'b00) begin n_fail++; $display("FAIL reset_src: got %b expected 00", active_src); end
    n_checks++;
    if (snoozing !== 1'b0) begin n_fail++; $display("FAIL reset_snoozing: got %0b expected 0", snoozing); end
    n_checks++;
    if (snooze_left !== 9'd0) begin n_fail++; $display("FAIL reset_left: got %0d expected 0", snooze_left); end
    step();
  endtask

  task automatic test_timer();
    timer_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (active_src !== 2'b01 || buzzer !== 1'b1) begin
        n_fail++;
        $display("FAIL timer_ring[%0d]: got src=%b buz=%0b expected src=01 buz=1", i, active_src, buzzer);
      end
    end
    step();
    n_checks++;
    if (active_src !== 2'b00 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_autostop: got src=%b buz=%0b expected src=00 buz=0", active_src, buzzer);
    end
    timer_req = 1'b0;
    step();
  endtask

  task automatic test_preempt();
    logic exp_b;
    timer_req = 1'b1;
    step();
    step();
    timer_req = 1'b0;
    alarm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      alarm_req = 1'b0;
      exp_b = (i % 2 == 0);
      n_checks++;
      if (active_src !== 2'b10 || buzzer !== exp_b) begin
        n_fail++;
        $display("FAIL preempt_alarm[%0d]: got src=%b buz=%0b expected src=10 buz=%0b", i, active_src, buzzer, exp_b);
      end
    end
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b01 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_resume: got src=%b buz=%0b expected src=01 buz=1", active_src, buzzer);
    end
    step();
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b00 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_stop: got src=%b buz=%0b expected src=00 buz=0", active_src, buzzer);
    end
    step();
  endtask

  task automatic test_snooze();
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    n_checks++;
    if (active_src !== 2'b10 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze_ring: got src=%b buz=%0b expected src=10 buz=1", active_src, buzzer);
    end
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b00 || snoozing !== 1'b1 || snooze_left !== 9'd5) begin
      n_fail++;
      $display("FAIL snooze_first: got src=%b snz=%0b left=%0d expected src=00 snz=1 left=5", active_src, snoozing, snooze_left);
    end
    for (int k = 4; k >= 1; k--) begin
      step();
      n_checks++;
      if (snooze_left !== 9'(k) || snoozing !== 1'b1 || active_src !== 2'b00) begin
        n_fail++;
        $display("FAIL snooze_count: got left=%0d snz=%0b src=%b expected left=%0d snz=1 src=00", snooze_left, snoozing, active_src, k);
      end
    end
    step();
    n_checks++;
    if (snooze_left !== 9'd0 || snoozing !== 1'b0 || active_src !== 2'b10 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze_rering: got left=%0d snz=%0b src=%b buz=%0b expected left=0 snz=0 src=10 buz=1", snooze_left, snoozing, active_src, buzzer);
    end
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b00 || snoozing !== 1'b1 || snooze_left !== 9'd5) begin
      n_fail++;
      $display("FAIL snooze_second: got src=%b snz=%0b left=%0d expected src=00 snz=1 left=5", active_src, snoozing, snooze_left);
    end
    repeat (5) step();
    n_checks++;
    if (active_src !== 2'b10) begin
      n_fail++;
      $display("FAIL snooze_rering2: got src=%b expected 10", active_src);
    end
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b00 || snoozing !== 1'b0 || snooze_left !== 9'd0) begin
      n_fail++;
      $display("FAIL snooze_limit: got src=%b snz=%0b left=%0d expected src=00 snz=0 left=0", active_src, snoozing, snooze_left);
    end
    repeat (6) step();
    n_checks++;
    if (active_src !== 2'b00) begin
      n_fail++;
      $display("FAIL snooze_limit_quiet: got src=%b expected 00", active_src);
    end
  endtask

  task automatic test_stop_and_snooze();
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b00 || snoozing !== 1'b0 || snooze_left !== 9'd0) begin
      n_fail++;
      $display("FAIL both_buttons: got src=%b snz=%0b left=%0d expected src=00 snz=0 left=0", active_src, snoozing, snooze_left);
    end
    step();
  endtask

  task automatic test_snooze_cancel();
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    n_checks++;
    if (snooze_left !== 9'd0 || snoozing !== 1'b0 || active_src !== 2'b00) begin
      n_fail++;
      $display("FAIL cancel_idle: got left=%0d snz=%0b src=%b expected left=0 snz=0 src=00", snooze_left, snoozing, active_src);
    end
    repeat (6) step();
    n_checks++;
    if (active_src !== 2'b00) begin
      n_fail++;
      $display("FAIL cancel_quiet: got src=%b expected 00", active_src);
    end
    // fresh alarm edge during a snooze restarts the ring immediately
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    step();
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    n_checks++;
    if (active_src !== 2'b10 || snooze_left !== 9'd0 || snoozing !== 1'b0) begin
      n_fail++;
      $display("FAIL fresh_alarm: got src=%b left=%0d snz=%0b expected src=10 left=0 snz=0", active_src, snooze_left, snoozing);
    end
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    n_checks++;
    if (active_src !== 2'b00) begin
      n_fail++;
      $display("FAIL fresh_stop: got src=%b expected 00", active_src);
    end
    step();
  endtask

  task automatic test_alarm_hold();
    int   rings;
    logic exp_b;
    logic [1:0] exp_s;
    rings = 0;
    alarm_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_s = (i < 8) ? 2'b10 : 2'b00;
      exp_b = (i < 8) ? (i % 2 == 0) : 1'b0;
      if (active_src == 2'b10) rings++;
      n_checks++;
      if (active_src !== exp_s || buzzer !== exp_b) begin
        n_fail++;
        $display("FAIL hold[%0d]: got src=%b buz=%0b expected src=%b buz=%0b", i, active_src, buzzer, exp_s, exp_b);
      end
    end
    n_checks++;
    if (rings !== 8) begin
      n_fail++;
      $display("FAIL hold_ring_len: got %0d expected 8", rings);
    end
    alarm_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    timer_req = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (buzzer !== 1'b0 || active_src !== 2'b00 || snoozing !== 1'b0 || snooze_left !== 9'd0) begin
      n_fail++;
      $display("FAIL midreset_out: got buz=%0b src=%b snz=%0b left=%0d expected all 0", buzzer, active_src, snoozing, snooze_left);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (active_src !== 2'b00 || buzzer !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_held[%0d]: got src=%b buz=%0b expected src=00 buz=0", i, active_src, buzzer);
      end
    end
    timer_req = 1'b0;
    step();
    timer_req = 1'b1;
    step();
    n_checks++;
    if (active_src !== 2'b01 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_newedge: got src=%b buz=%0b expected src=01 buz=1", active_src, buzzer);
    end
    timer_req = 1'b0;
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_timer();
    test_preempt();
    test_snooze();
    test_stop_and_snooze();
    test_snooze_cancel();
    test_alarm_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
